// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// pipeline_stall_controller - interlock sequencer for load-use, memory wait
// and taken-branch flush.                                      Revision 1.0
// ============================================================================
module pipeline_stall_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mr_memreq,
  input  logic             mem_ready,
  input  logic             branch_taken_ex,
  output logic             pc_write,
  output logic             if_pr_write,
  output logic             pr_id_write,
  output logic             id_ex_write,
  output logic             ex_mr_write,
  output logic             front_flush,
  output logic             id_ex_bubble,
  output logic             mr_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0]  c_run          = 2'd0;
  localparam logic [1:0]  c_flush        = 2'd1;
  localparam logic [1:0]  c_mem_wait     = 2'd2;
  localparam logic [1:0]  c_hang         = 2'd3;
  localparam logic [2:0]  c_flush_reload = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] c_timeout      = 16'(MEM_TIMEOUT);

  logic [1:0]       r_state, w_state_next;
  logic [2:0]       r_flush_cnt, w_flush_cnt_next;
  logic [15:0]      r_wait_cnt, w_wait_cnt_next, w_wait_inc;
  logic             r_mem_timeout, w_set_timeout;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_mem_hold, w_load_use, w_flushing, w_frozen;
  logic w_pc_write, w_if_pr_write, w_pr_id_write, w_id_ex_write, w_ex_mr_write;
  logic w_front_flush, w_id_ex_bubble, w_mr_wb_bubble;

  assign w_mem_hold = mr_memreq & ~mem_ready;
  assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign w_flushing = (r_state == c_flush);
  // The whole pipe holds while memory is outstanding or the access has hung.
  assign w_frozen   = (r_state == c_hang) ||
                      ((r_state == c_mem_wait) && !mem_ready) ||
                      (((r_state == c_run) || w_flushing) && w_mem_hold);
  assign w_wait_inc = (r_state == c_mem_wait) ? r_wait_cnt + 16'd1 : 16'd1;

  always_comb begin
    w_pc_write       = 1'b1;
    w_if_pr_write    = 1'b1;
    w_pr_id_write    = 1'b1;
    w_id_ex_write    = 1'b1;
    w_ex_mr_write    = 1'b1;
    w_front_flush    = 1'b0;
    w_id_ex_bubble   = 1'b0;
    w_mr_wb_bubble   = 1'b0;
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_wait_cnt_next  = r_wait_cnt;
    w_set_timeout    = 1'b0;

    if (w_frozen) begin
      w_pc_write     = 1'b0;
      w_if_pr_write  = 1'b0;
      w_pr_id_write  = 1'b0;
      w_id_ex_write  = 1'b0;
      w_ex_mr_write  = 1'b0;
      w_mr_wb_bubble = 1'b1;
      if (r_state != c_hang) begin
        w_wait_cnt_next = w_wait_inc;
        if (w_wait_inc >= c_timeout) begin
          w_state_next  = c_hang;
          w_set_timeout = 1'b1;
        end else begin
          w_state_next = c_mem_wait;
        end
      end
    end else begin
      if (r_state == c_mem_wait) begin
        w_wait_cnt_next = 16'd0;
        w_state_next    = (r_flush_cnt != 3'd0) ? c_flush : c_run;
      end
      if (branch_taken_ex) begin
        w_front_flush    = 1'b1;
        w_id_ex_bubble   = !w_flushing;
        w_flush_cnt_next = c_flush_reload;
        w_state_next     = (c_flush_reload != 3'd0) ? c_flush : c_run;
      end else if (w_flushing) begin
        // The ID instruction is being killed, so load-use is not evaluated.
        w_front_flush    = 1'b1;
        w_flush_cnt_next = r_flush_cnt - 3'd1;
        w_state_next     = (r_flush_cnt == 3'd1) ? c_run : c_flush;
      end else if (w_load_use) begin
        w_pc_write     = 1'b0;
        w_if_pr_write  = 1'b0;
        w_pr_id_write  = 1'b0;
        w_id_ex_bubble = 1'b1;
      end
    end
  end

  assign pc_write     = w_pc_write     & ~reset;
  assign if_pr_write  = w_if_pr_write  & ~reset;
  assign pr_id_write  = w_pr_id_write  & ~reset;
  assign id_ex_write  = w_id_ex_write  & ~reset;
  assign ex_mr_write  = w_ex_mr_write  & ~reset;
  assign front_flush  = w_front_flush  & ~reset;
  assign id_ex_bubble = w_id_ex_bubble & ~reset;
  assign mr_wb_bubble = w_mr_wb_bubble & ~reset;
  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= c_run;
      r_flush_cnt    <= 3'd0;
      r_wait_cnt     <= 16'd0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_wait_cnt  <= w_wait_cnt_next;
      if (w_set_timeout) begin
        r_mem_timeout <= 1'b1;
      end
      if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// Bench for pipeline_stall_controller: two parameterisations share stimulus and
// are compared each cycle against a behavioural model, plus directed checks.
module tb_pipeline_stall_controller;

  localparam int     FC_A = 2;
  localparam int     TO_A = 255;
  localparam longint SMAX_A = 64'hFFFF_FFFF;
  localparam int     FC_B = 3;
  localparam int     TO_B = 4;
  localparam longint SMAX_B = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rt, ex_memread, mr_memreq, mem_ready, branch_taken_ex;

  logic pc_a, ifpr_a, prid_a, idex_a, exmr_a, ff_a, idb_a, mrb_a, mem_timeout_a;
  logic pc_b, ifpr_b, prid_b, idex_b, exmr_b, ff_b, idb_b, mrb_b, mem_timeout_b;
  logic [31:0] stall_cycles_a;
  logic [3:0]  stall_cycles_b;
  logic [7:0]  outs_a, outs_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.FLUSH_CYCLES(FC_A), .MEM_TIMEOUT(TO_A), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mr_memreq(mr_memreq), .mem_ready(mem_ready),
    .branch_taken_ex(branch_taken_ex), .pc_write(pc_a), .if_pr_write(ifpr_a),
    .pr_id_write(prid_a), .id_ex_write(idex_a), .ex_mr_write(exmr_a), .front_flush(ff_a),
    .id_ex_bubble(idb_a), .mr_wb_bubble(mrb_a), .mem_timeout(mem_timeout_a),
    .stall_cycles(stall_cycles_a));

  pipeline_stall_controller #(.FLUSH_CYCLES(FC_B), .MEM_TIMEOUT(TO_B), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mr_memreq(mr_memreq), .mem_ready(mem_ready),
    .branch_taken_ex(branch_taken_ex), .pc_write(pc_b), .if_pr_write(ifpr_b),
    .pr_id_write(prid_b), .id_ex_write(idex_b), .ex_mr_write(exmr_b), .front_flush(ff_b),
    .id_ex_bubble(idb_b), .mr_wb_bubble(mrb_b), .mem_timeout(mem_timeout_b),
    .stall_cycles(stall_cycles_b));

  // Output vector order: {pc, if_pr, pr_id, id_ex, ex_mr, front_flush, id_ex_bubble, mr_wb_bubble}
  assign outs_a = {pc_a, ifpr_a, prid_a, idex_a, exmr_a, ff_a, idb_a, mrb_a};
  assign outs_b = {pc_b, ifpr_b, prid_b, idex_b, exmr_b, ff_b, idb_b, mrb_b};

  // Model: waited>0 means a memory access is outstanding; flush_left>0 while
  // not waiting means front-end kill cycles remain.
  typedef struct {
    int     flush_left;
    int     waited;
    bit     hung;
    bit     timeout;
    longint stalls;
  } mstate_t;

  mstate_t ms_a, ms_b, upd_n_a, upd_n_b, cmp_n_a, cmp_n_b;
  logic [7:0] upd_o_a, upd_o_b, cmp_o_a, cmp_o_b;

  function automatic mstate_t m_init();
    mstate_t s;
    s.flush_left = 0;
    s.waited     = 0;
    s.hung       = 1'b0;
    s.timeout    = 1'b0;
    s.stalls     = 0;
    return s;
  endfunction

  function automatic void model_step(input int fc, input int tmo, input longint smax,
                                     input mstate_t s, output logic [7:0] o, output mstate_t n);
    bit hold_req, lu, flushing, frozen;
    n        = s;
    hold_req = mr_memreq && !mem_ready;
    lu       = ex_memread && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    flushing = (s.flush_left > 0) && (s.waited == 0);
    frozen   = s.hung || ((s.waited > 0) ? !mem_ready : hold_req);
    o = 8'b1111_1000;
    if (frozen) begin
      o = 8'b0000_0001;
      if (!s.hung) begin
        n.waited = s.waited + 1;
        if (n.waited >= tmo) begin
          n.hung    = 1'b1;
          n.timeout = 1'b1;
        end
      end
    end else begin
      n.waited = 0;
      if (branch_taken_ex) begin
        o = flushing ? 8'b1111_1100 : 8'b1111_1110;
        n.flush_left = fc - 1;
      end else if (flushing) begin
        o = 8'b1111_1100;
        n.flush_left = s.flush_left - 1;
      end else if (lu) begin
        o = 8'b0001_1010;
      end
    end
    if (!o[7] && (s.stalls < smax)) n.stalls = s.stalls + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_a <= m_init();
      ms_b <= m_init();
    end else begin
      model_step(FC_A, TO_A, SMAX_A, ms_a, upd_o_a, upd_n_a);
      model_step(FC_B, TO_B, SMAX_B, ms_b, upd_o_b, upd_n_b);
      ms_a <= upd_n_a;
      ms_b <= upd_n_b;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("rst_outs_a", 64'(outs_a), 64'd0);
      check("rst_outs_b", 64'(outs_b), 64'd0);
      check("rst_stall_a", 64'(stall_cycles_a), 64'd0);
      check("rst_timeout_b", 64'(mem_timeout_b), 64'd0);
    end else begin
      model_step(FC_A, TO_A, SMAX_A, ms_a, cmp_o_a, cmp_n_a);
      model_step(FC_B, TO_B, SMAX_B, ms_b, cmp_o_b, cmp_n_b);
      check("model_outs_a", 64'(outs_a), 64'(cmp_o_a));
      check("model_outs_b", 64'(outs_b), 64'(cmp_o_b));
      check("model_timeout_a", 64'(mem_timeout_a), 64'(ms_a.timeout));
      check("model_timeout_b", 64'(mem_timeout_b), 64'(ms_b.timeout));
      check("model_stall_a", 64'(stall_cycles_a), 64'(ms_a.stalls));
      check("model_stall_b", 64'(stall_cycles_b), 64'(ms_b.stalls));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
    mr_memreq = 1'b0; mem_ready = 1'b1; branch_taken_ex = 1'b0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #3;
    check("reset_outs_a", 64'(outs_a), 64'd0);
    check("reset_stall_a", 64'(stall_cycles_a), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("run_idle", 64'(outs_a), 64'hF8);
    check("run_timeout", 64'(mem_timeout_a), 64'd0);

    // load-use through Rt
    tick();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b1;
    #1 check("load_use", 64'(outs_a), 64'h1A);
    tick();
    idle();
    #1 check("load_use_after", 64'(outs_a), 64'hF8);
    check("load_use_stall", 64'(stall_cycles_a), 64'd1);
    ex_memread = 1'b1; ex_rd = 5'd0; id_uses_rt = 1'b1;
    #1 check("load_use_r0", 64'(outs_a), 64'hF8);
    ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1 check("load_use_rt_unused", 64'(outs_a), 64'hF8);
    tick();
    idle();
    #1 check("no_extra_stall", 64'(stall_cycles_a), 64'd1);

    // three-cycle memory wait
    mr_memreq = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("mem_wait", 64'(outs_a), 64'h01);
      tick();
    end
    mem_ready = 1'b1;
    #1 check("mem_release", 64'(outs_a), 64'hF8);
    tick();
    idle();
    #1 check("mem_wait_stall", 64'(stall_cycles_a), 64'd4);

    // branch flush
    branch_taken_ex = 1'b1;
    #1 check("branch_first", 64'(outs_a), 64'hFE);
    tick();
    branch_taken_ex = 1'b0;
    #1 check("branch_flush2", 64'(outs_a), 64'hFC);
    tick();
    #1 check("branch_done", 64'(outs_a), 64'hF8);
    check("branch_stall", 64'(stall_cycles_a), 64'd4);

    // branch coinciding with a two-cycle memory wait
    branch_taken_ex = 1'b1; mr_memreq = 1'b1; mem_ready = 1'b0;
    #1 check("br_mem_freeze1", 64'(outs_a), 64'h01);
    tick();
    #1 check("br_mem_freeze2", 64'(outs_a), 64'h01);
    tick();
    mem_ready = 1'b1;
    #1 check("br_on_release", 64'(outs_a), 64'hFE);
    tick();
    idle();
    #1 check("br_mem_flush", 64'(outs_a), 64'hFC);
    tick();
    #1 check("br_mem_done", 64'(outs_a), 64'hF8);
    check("br_mem_stall", 64'(stall_cycles_a), 64'd6);

    // timeout on the MEM_TIMEOUT=4 instance
    mr_memreq = 1'b1; mem_ready = 1'b0;
    tick(); tick(); tick();
    #1 check("timeout_not_yet", 64'(mem_timeout_b), 64'd0);
    tick();
    #1 check("timeout_set", 64'(mem_timeout_b), 64'd1);
    check("hang_outs", 64'(outs_b), 64'h01);
    mem_ready = 1'b1;
    #1 check("hang_ignores_ready", 64'(outs_b), 64'h01);
    check("other_released", 64'(outs_a), 64'hF8);
    tick();
    #1 check("timeout_sticky", 64'(mem_timeout_b), 64'd1);
    check("timeout_a_clear", 64'(mem_timeout_a), 64'd0);
    mem_ready = 1'b0;
    repeat (20) tick();
    #1 check("stall_saturate", 64'(stall_cycles_b), 64'd15);

    // asynchronous reset during FLUSH
    idle();
    tick();
    branch_taken_ex = 1'b1;
    #1 check("pre_reset_branch", 64'(outs_a), 64'hFE);
    tick();
    branch_taken_ex = 1'b0;
    #1 check("in_flush", 64'(outs_a), 64'hFC);
    reset = 1'b1;
    #1 check("reset_mid_flush_a", 64'(outs_a), 64'd0);
    check("reset_mid_flush_b", 64'(outs_b), 64'd0);
    check("reset_stall_clear", 64'(stall_cycles_a), 64'd0);
    check("reset_timeout_clear", 64'(mem_timeout_b), 64'd0);
    tick();
    reset = 1'b0;
    #1 check("after_reset_a", 64'(outs_a), 64'hF8);
    check("after_reset_b", 64'(outs_b), 64'hF8);
    check("after_reset_stall", 64'(stall_cycles_b), 64'd0);

    // randomized segments, each opened by a mid-cycle reset
    for (int seg = 0; seg < 25; seg++) begin
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 160; c++) begin
        tick();
        mr_memreq       = 1'($urandom_range(0, 1));
        mem_ready       = (seg % 3 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
        branch_taken_ex = ($urandom_range(0, 9) == 0);
        ex_memread      = ($urandom_range(0, 9) < 3);
        ex_rd           = 5'($urandom_range(0, 3));
        id_rs           = 5'($urandom_range(0, 3));
        id_rt           = 5'($urandom_range(0, 3));
        id_uses_rt      = 1'($urandom_range(0, 1));
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
